// File: rtl/filtr_pkg.sv
// filtr_pkg: shared definitions for the filter sequencing controller.
//   - DEF_DATA_SIZE / DEF_TIMEOUT / DEF_CNT_SIZE : default parameter values
//   - state_e : sequencer FSM state enumeration (also exported for debug)
package filtr_pkg;

  localparam int DEF_DATA_SIZE = 24;
  localparam int DEF_TIMEOUT   = 256;
  localparam int DEF_CNT_SIZE  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating up-counter.
//   clk   : rising-edge clock
//   reset : synchronous active-low clear (takes priority over inc)
//   inc   : count enable, one step per cycle
//   value : current count, sticks at all-ones
module sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/filtr_seq_ctrl.sv
// filtr_seq_ctrl: sequences ADC samples through an external filter core
// (or around it in bypass) and presents each result to a DAC-side consumer.
//
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-low reset
//   in_strobe, in_data    : one-cycle ADC sample strobe and sample
//   bypass                : route the sample straight to the output (sampled
//                           only when a strobe is accepted in IDLE)
//   flt_data_in           : registered sample presented to the filter core
//   flt_sample            : one-cycle trigger to the filter core
//   flt_done/flt_data_out : filter completion flag and result
//   out_valid/out_ready   : result handshake; a transfer happens on a cycle
//                           where both are 1. out_valid stays 1 and out_data
//                           stays constant until that transfer.
//   out_data              : result register
//   busy                  : 1 whenever the sequencer is not in IDLE
//   drop_cnt, tmo_cnt     : saturating counts of dropped strobes / timeouts
//   dbg_state             : current FSM state for observation
module filtr_seq_ctrl
  import filtr_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_SIZE  = DEF_CNT_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_strobe,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 bypass,
  output logic [DATA_SIZE-1:0] flt_data_in,
  output logic                 flt_sample,
  input  logic                 flt_done,
  input  logic [DATA_SIZE-1:0] flt_data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 busy,
  output logic [CNT_SIZE-1:0]  drop_cnt,
  output logic [CNT_SIZE-1:0]  tmo_cnt,
  output state_e               dbg_state
);

  // The WAIT counter only has to reach TIMEOUT-1.
  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;

  logic ld_sample;   // capture in_data for the filter core
  logic ld_bypass;   // out_data <= in_data
  logic ld_result;   // out_data <= flt_data_out
  logic ld_pass;     // out_data <= flt_data_in (filter timed out)
  logic wait_clr;
  logic wait_inc;
  logic drop_inc;
  logic tmo_inc;

  always_comb begin
    state_d   = state_q;
    ld_sample = 1'b0;
    ld_bypass = 1'b0;
    ld_result = 1'b0;
    ld_pass   = 1'b0;
    wait_clr  = 1'b0;
    wait_inc  = 1'b0;
    tmo_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_strobe) begin
          if (bypass) begin
            ld_bypass = 1'b1;
            state_d   = ST_OUT;
          end else begin
            ld_sample = 1'b1;
            state_d   = ST_TRIG;
          end
        end
      end
      ST_TRIG: begin
        // flt_done is deliberately not looked at here.
        wait_clr = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion beats a coincident timeout.
        if (flt_done) begin
          ld_result = 1'b1;
          state_d   = ST_OUT;
        end else if (wait_q == WAIT_LAST) begin
          ld_pass = 1'b1;
          tmo_inc = 1'b1;
          state_d = ST_OUT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The source cannot stall: any strobe outside IDLE is lost.
  assign drop_inc = in_strobe && (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      flt_data_in <= '0;
      out_data    <= '0;
    end else begin
      state_q <= state_d;
      if (wait_clr) begin
        wait_q <= '0;
      end else if (wait_inc) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
      if (ld_sample) begin
        flt_data_in <= in_data;
      end
      if (ld_bypass) begin
        out_data <= in_data;
      end else if (ld_result) begin
        out_data <= flt_data_out;
      end else if (ld_pass) begin
        out_data <= flt_data_in;
      end
    end
  end

  // Gated by reset so these are low for the whole reset period, not just
  // after the first reset edge.
  assign flt_sample = reset && (state_q == ST_TRIG);
  assign out_valid  = reset && (state_q == ST_OUT);
  assign busy       = reset && (state_q != ST_IDLE);
  assign dbg_state  = state_q;

  sat_cnt #(.WIDTH(CNT_SIZE)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .value (drop_cnt)
  );

  sat_cnt #(.WIDTH(CNT_SIZE)) u_tmo_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (tmo_inc),
    .value (tmo_cnt)
  );

endmodule

// File: tb/tb_filtr_seq_ctrl.sv
// tb_filtr_seq_ctrl: directed bench for filtr_seq_ctrl with a job-level
// reference model, a per-cycle compare process, a result scoreboard and
// hand-computed literal checks.
module tb_filtr_seq_ctrl;
  import filtr_pkg::*;

  localparam int DW      = 24;
  localparam int TMO     = 16;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          in_strobe = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          bypass = 1'b0;
  logic [DW-1:0] flt_data_in;
  logic          flt_sample;
  wire           flt_done;
  wire  [DW-1:0] flt_data_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] tmo_cnt;
  state_e        dbg_state;

  filtr_seq_ctrl #(.DATA_SIZE(DW), .TIMEOUT(TMO), .CNT_SIZE(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_strobe    (in_strobe),
    .in_data      (in_data),
    .bypass       (bypass),
    .flt_data_in  (flt_data_in),
    .flt_sample   (flt_sample),
    .flt_done     (flt_done),
    .flt_data_out (flt_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .drop_cnt     (drop_cnt),
    .tmo_cnt      (tmo_cnt),
    .dbg_state    (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- filter core responder ----------------
  // Raises flt_done rsp_delay cycles after the cycle in which flt_sample
  // was seen (rsp_delay=0 means never). man_done lets a scenario force it.
  int            rsp_delay = 0;
  int            rsp_cnt = 0;
  logic          rsp_pulse = 1'b0;
  logic          man_done = 1'b0;
  logic [DW-1:0] rsp_val = '0;

  assign flt_done     = rsp_pulse | man_done;
  assign flt_data_out = rsp_val;

  always @(negedge clk) begin
    rsp_pulse = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) rsp_pulse = 1'b1;
    end
    if (flt_sample === 1'b1 && rsp_delay > 0) rsp_cnt = rsp_delay;
  end

  int n_trig = 0;
  always @(posedge clk) if (flt_sample === 1'b1) n_trig++;

  // ---------------- reference model + scoreboard ----------------
  // A job starts when a strobe arrives with no job in flight. m_age counts
  // clock edges since acceptance; a filtered job triggers the core at age 1
  // and then waits, its wait index being m_age-2.
  logic [DW-1:0] exp_q[$];
  bit            m_active = 0;
  bit            m_done = 0;
  int            m_age = 0;
  logic [DW-1:0] m_sample = '0;
  logic [DW-1:0] m_result = '0;
  int            m_drop = 0;
  int            m_tmo = 0;

  function automatic void m_finish(input logic [DW-1:0] v);
    m_result = v;
    m_done   = 1;
    exp_q.push_back(v);
  endfunction

  always @(posedge clk) begin
    logic [DW-1:0] e;
    // Handshake on pre-edge DUT values.
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", {8'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_out_data", {8'h0, out_data}, {8'h0, e});
      end
    end
    if (!reset) begin
      m_active = 0; m_done = 0; m_age = 0;
      m_sample = '0; m_result = '0; m_drop = 0; m_tmo = 0;
      exp_q.delete();
    end else begin
      if (in_strobe && m_active && m_drop < CNT_MAX) m_drop++;
      if (m_active && m_done) begin
        if (out_ready) begin m_active = 0; m_done = 0; end
      end else if (m_active) begin
        if (m_age >= 2) begin
          if (flt_done) m_finish(flt_data_out);
          else if (m_age - 2 == TMO - 1) begin
            m_finish(m_sample);
            if (m_tmo < CNT_MAX) m_tmo++;
          end
        end
        m_age++;
      end else if (in_strobe) begin
        m_active = 1;
        m_age    = 1;
        if (bypass) m_finish(in_data);
        else m_sample = in_data;
      end
    end
  end

  // Per-cycle compare, after outputs settle.
  always @(posedge clk) begin
    #2;
    chk("busy",        {31'h0, busy},       {31'h0, m_active});
    chk("out_valid",   {31'h0, out_valid},  {31'h0, m_active && m_done});
    chk("flt_sample",  {31'h0, flt_sample}, {31'h0, m_active && !m_done && m_age == 1});
    chk("out_data",    {8'h0, out_data},    {8'h0, m_result});
    chk("flt_data_in", {8'h0, flt_data_in}, {8'h0, m_sample});
    chk("drop_cnt",    {24'h0, drop_cnt},   32'(m_drop));
    chk("tmo_cnt",     {24'h0, tmo_cnt},    32'(m_tmo));
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [DW-1:0] d, input logic b);
    @(negedge clk);
    in_strobe = 1'b1; in_data = d; bypass = b;
    @(negedge clk);
    in_strobe = 1'b0;
  endtask

  // Called right after strobe(); lat counts edges since the strobe edge.
  task automatic wait_valid(input int max, output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < max) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_reached", {31'h0, out_valid}, 32'h1);
  endtask

  task automatic handshake();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("idle_after_handshake", {31'h0, busy}, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int lat;

    // Reset state
    idle(3);
    chk("rst_busy",        {31'h0, busy},       32'h0);
    chk("rst_out_valid",   {31'h0, out_valid},  32'h0);
    chk("rst_flt_sample",  {31'h0, flt_sample}, 32'h0);
    chk("rst_out_data",    {8'h0, out_data},    32'h0);
    chk("rst_flt_data_in", {8'h0, flt_data_in}, 32'h0);
    chk("rst_drop_cnt",    {24'h0, drop_cnt},   32'h0);
    chk("rst_tmo_cnt",     {24'h0, tmo_cnt},    32'h0);
    reset = 1'b1;
    idle(2);

    // Filtered sample, core answers 5 cycles after the trigger; bypass
    // flips mid-operation and must not matter.
    n_trig = 0; rsp_delay = 5; rsp_val = 24'h0ABCDE;
    strobe(24'h123456, 1'b0);
    bypass = 1'b1;
    wait_valid(40, lat);
    chk("filt_out_data",    {8'h0, out_data},    32'h000A_BCDE);
    chk("filt_flt_data_in", {8'h0, flt_data_in}, 32'h0012_3456);
    chk("filt_trig_once",   32'(n_trig),         32'd1);
    handshake();
    bypass = 1'b0;

    // Bypass: result on the next cycle, core never triggered.
    n_trig = 0;
    strobe(24'hFFFFFF, 1'b1);
    wait_valid(5, lat);
    chk("byp_latency",  32'(lat),          32'd1);
    chk("byp_out_data", {8'h0, out_data},  32'h00FF_FFFF);
    handshake();
    chk("byp_no_trig",  32'(n_trig),       32'd0);

    // Core never answers: pass-through after TIMEOUT wait cycles.
    rsp_delay = 0;
    strobe(24'h5A5A5A, 1'b0);
    chk("tmo_trig_seen", {31'h0, flt_sample}, 32'h1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    // One edge from TRIG into WAIT, then 16 cycles in WAIT.
    chk("tmo_latency",  32'(lat),          32'd17);
    chk("tmo_out_data", {8'h0, out_data},  32'h005A_5A5A);
    chk("tmo_count",    {24'h0, tmo_cnt},  32'd1);
    handshake();

    // Consumer stalls: strobes every 4 cycles are dropped.
    strobe(24'h000111, 1'b1);
    wait_valid(5, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_strobe = (i % 4 == 0);
      in_data   = 24'(i);
    end
    @(negedge clk); in_strobe = 1'b0;
    chk("drop_five",       {24'h0, drop_cnt}, 32'd5);
    chk("drop_data_held",  {8'h0, out_data},  32'h0000_0111);
    chk("drop_valid_held", {31'h0, out_valid}, 32'h1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_strobe = 1'b1;
    end
    @(negedge clk); in_strobe = 1'b0;
    chk("drop_saturated", {24'h0, drop_cnt}, 32'd255);
    handshake();

    // Reset while waiting, strobe during reset, then a late done pulse.
    rsp_delay = 0; rsp_val = 24'h0F0F0F;
    strobe(24'h246801, 1'b0);
    @(negedge clk);
    reset = 1'b0; in_strobe = 1'b1;
    @(negedge clk);
    reset = 1'b1; in_strobe = 1'b0; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("late_done_no_valid", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
    end
    chk("abort_busy", {31'h0, busy},     32'h0);
    chk("abort_drop", {24'h0, drop_cnt}, 32'h0);
    chk("abort_tmo",  {24'h0, tmo_cnt},  32'h0);
    chk("abort_data", {8'h0, out_data},  32'h0);

    // Done on the exact timeout cycle: result wins, no timeout counted.
    rsp_delay = 16; rsp_val = 24'h777777;
    strobe(24'h800001, 1'b0);
    wait_valid(40, lat);
    chk("tie_out_data", {8'h0, out_data}, 32'h0077_7777);
    chk("tie_tmo",      {24'h0, tmo_cnt}, 32'h0);
    handshake();

    // Fastest filtered path, consumer already ready.
    rsp_delay = 1; rsp_val = 24'h800000;
    out_ready = 1'b1;
    strobe(24'hFEDCBA, 1'b0);
    wait_valid(20, lat);
    chk("fast_out_data", {8'h0, out_data}, 32'h0080_0000);
    @(negedge clk);
    out_ready = 1'b0;
    chk("fast_idle", {31'h0, busy}, 32'h0);
    idle(3);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
